datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 clk  input  1  sole clock; all register loads occur on its rising edge.
REQ-002 clr  input  1  reset, asynchronous and active-low; clears every register.
REQ-003 PCout, Zlowout, MDRout, R2out, R4out  input  1 each  bus-source selects.
REQ-004 MARin, Zin, PCin, MDRin, IRin, Yin, R2in, R4in, R5in  input  1 each  register load enables.
REQ-005 read  input  1  MDR input mux select: 1 selects Mdatain, 0 selects the bus.
REQ-006 IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT  input  1 each  ALU operation selects.
REQ-007 Mdatain  input  32  memory read data.
REQ-008 R0..R15, Hi, Lo, PC, MAR, MDR, IR  output  32 each  register contents.
REQ-009 Z  output  64  Z register contents.
REQ-010 bus_mux_out  output  32  internal bus value.
REQ-011 ALUout  output  64  combinational ALU result.

Function
REQ-012 Bus source priority: MDRout > PCout > Zlowout (drives Z[31:0]) > R2out > R4out; the bus SHALL be 0 when no select is asserted.
REQ-013 Each register with an enable SHALL load on the rising clk edge while its enable is 1 and SHALL hold otherwise.
REQ-014 PC, MAR, IR, Y, R2, R4 and R5 SHALL load from bus_mux_out.
REQ-015 MDR SHALL load the read-mux output (per REQ-005).
REQ-016 Z SHALL load the full 64-bit ALUout.
REQ-017 R0, R1, R3, R6..R15, Hi and Lo have no load path and SHALL remain at 0.
REQ-018 ALU operands: A = Y, B = bus_mux_out; results combinational, with no added latency.
REQ-019 Op priority: IncPC > ADD > SUB > AND > OR > SHR > SHL > ROR > ROL > NEG > NOT; ALUout SHALL be 0 when no op is asserted.
REQ-020 Op results: IncPC = B+1; ADD = A+B; SUB = A-B; AND = A&B; OR = A|B; NOT = ~B; NEG = 0-B (two's complement).
REQ-021 Shift and rotate ops use A as the data and B[4:0] as the amount; SHR is logical (zero fill); amount 0 SHALL pass A unchanged.
REQ-022 All op results are 32-bit with wrap-around; ALUout[63:32] SHALL be 0 for every op.
REQ-023 A register whose enable is 1 while it also drives the bus SHALL capture the pre-edge bus value (no combinational loop).

Reset
REQ-024 While clr = 0, all registers (PC, MAR, MDR, IR, Y, Z, R0..R15, Hi, Lo) SHALL be 0 immediately, regardless of clk.
REQ-025 Loads SHALL resume at the first rising clk edge after clr returns to 1; reset asserted mid-sequence SHALL discard all state.

Configuration
REQ-026 Macro DATAPATH_ROTATE_EN: when defined, ROL and ROR SHALL rotate per REQ-021.
REQ-027 When DATAPATH_ROTATE_EN is undefined, ROL and ROR SHALL yield ALUout = 0 and all other ops SHALL be unchanged.

Verification
REQ-028 Load path: Mdatain=4, read=1, MDRin=1 for one edge, then MDRout=1, R2in=1 -> R2=4; repeat with value 2 into R4 and PC, and 26 into R5 -> R4=2, PC=2, R5=0x1A.
REQ-029 Fetch: PCout, MARin, IncPC, Zin with PC=2 -> MAR=2, Z=3; then Zlowout, PCin -> PC=3; then Mdatain=0x4A920000 via MDR into IR -> IR=0x4A920000.
REQ-030 NEG: R4=2, R4out, NEG, Zin -> Z=0x00000000_FFFFFFFE; then Zlowout, R5in -> R5=0xFFFFFFFE.
REQ-031 R2=4 loaded into Y, then R4=2 on the bus: ADD -> Z=6; SUB -> Z=2; SHL -> Z=16; SHR -> Z=1; AND -> Z=0; OR -> Z=6.
REQ-032 Rotates: ROR with Y=4, B=2 -> Z=1; ROL with Y=0x80000000, B=1 -> Z=1; with DATAPATH_ROTATE_EN undefined both -> Z=0.
REQ-033 Reset: drive clr=0 mid-sequence between clock edges -> all register outputs read 0 before the next edge; multiple out-selects asserted together -> the bus follows REQ-012.

Source files
------------

// File: rtl/datapath_if.sv
// Datapath control/observation bundle: bus-source selects, register load
// enables, ALU op selects, memory read data, and all register/bus/ALU views.
interface datapath_if;

    // Bus-source selects
    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        R2out;
    logic        R4out;

    // Register load enables
    logic        MARin;
    logic        Zin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        R2in;
    logic        R4in;
    logic        R5in;

    // MDR input mux select (1 = memory, 0 = bus)
    logic        read;

    // ALU op selects
    logic        IncPC;
    logic        ADD;
    logic        SUB;
    logic        AND;
    logic        OR;
    logic        SHR;
    logic        SHL;
    logic        ROR;
    logic        ROL;
    logic        NEG;
    logic        NOT;

    // Memory read data
    logic [31:0] Mdatain;

    // Register contents
    logic [31:0] R0;
    logic [31:0] R1;
    logic [31:0] R2;
    logic [31:0] R3;
    logic [31:0] R4;
    logic [31:0] R5;
    logic [31:0] R6;
    logic [31:0] R7;
    logic [31:0] R8;
    logic [31:0] R9;
    logic [31:0] R10;
    logic [31:0] R11;
    logic [31:0] R12;
    logic [31:0] R13;
    logic [31:0] R14;
    logic [31:0] R15;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic [31:0] PC;
    logic [31:0] MAR;
    logic [31:0] MDR;
    logic [31:0] IR;
    logic [63:0] Z;

    // Internal bus and combinational ALU result
    logic [31:0] bus_mux_out;
    logic [63:0] ALUout;

    // Controller side: drives selects/enables, observes state
    modport master (
        output PCout, Zlowout, MDRout, R2out, R4out,
        output MARin, Zin, PCin, MDRin, IRin, Yin, R2in, R4in, R5in,
        output read,
        output IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
        output Mdatain,
        input  R0, R1, R2, R3, R4, R5, R6, R7,
        input  R8, R9, R10, R11, R12, R13, R14, R15,
        input  Hi, Lo, PC, MAR, MDR, IR, Z,
        input  bus_mux_out, ALUout
    );

    // Datapath side
    modport slave (
        input  PCout, Zlowout, MDRout, R2out, R4out,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, R2in, R4in, R5in,
        input  read,
        input  IncPC, ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
        input  Mdatain,
        output R0, R1, R2, R3, R4, R5, R6, R7,
        output R8, R9, R10, R11, R12, R13, R14, R15,
        output Hi, Lo, PC, MAR, MDR, IR, Z,
        output bus_mux_out, ALUout
    );

endinterface

// File: rtl/datapath.sv
// Single-bus CPU datapath: priority bus mux, register file slice, MDR read
// mux, Y/Z ALU staging registers and a combinational 32-bit ALU.
// Optional feature macro: DATAPATH_ROTATE_EN enables the ROR/ROL ops; when
// undefined those ops produce zero and everything else is unchanged.
module datapath (
    input  logic      clk,
    input  logic      clr,
    datapath_if.slave dp
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DWORD_W = 64;
    localparam int unsigned SHAMT_W = 5;

    logic [WORD_W-1:0]  pc;
    logic [WORD_W-1:0]  mar;
    logic [WORD_W-1:0]  mdr;
    logic [WORD_W-1:0]  ir;
    logic [WORD_W-1:0]  y;
    logic [WORD_W-1:0]  r2;
    logic [WORD_W-1:0]  r4;
    logic [WORD_W-1:0]  r5;
    logic [DWORD_W-1:0] z;

    logic [WORD_W-1:0]  bus;
    logic [WORD_W-1:0]  mdr_in;
    logic [WORD_W-1:0]  alu_a;
    logic [WORD_W-1:0]  alu_b;
    logic [SHAMT_W-1:0] alu_amt;
    logic [WORD_W-1:0]  alu_res;
    logic [DWORD_W-1:0] alu_out;

    // Bus source mux, fixed priority MDR > PC > Zlow > R2 > R4, idle bus is 0
    always_comb begin
        bus = '0;
        if (dp.MDRout) begin
            bus = mdr;
        end else if (dp.PCout) begin
            bus = pc;
        end else if (dp.Zlowout) begin
            bus = z[WORD_W-1:0];
        end else if (dp.R2out) begin
            bus = r2;
        end else if (dp.R4out) begin
            bus = r4;
        end
    end

    // MDR input mux: memory data on a read cycle, bus otherwise
    assign mdr_in = dp.read ? dp.Mdatain : bus;

    assign alu_a   = y;
    assign alu_b   = bus;
    assign alu_amt = alu_b[SHAMT_W-1:0];

    // ALU op select with fixed priority; shifts/rotates take A as data, B[4:0] as amount
    always_comb begin
        alu_res = '0;
        if (dp.IncPC) begin
            alu_res = alu_b + WORD_W'(1);
        end else if (dp.ADD) begin
            alu_res = alu_a + alu_b;
        end else if (dp.SUB) begin
            alu_res = alu_a - alu_b;
        end else if (dp.AND) begin
            alu_res = alu_a & alu_b;
        end else if (dp.OR) begin
            alu_res = alu_a | alu_b;
        end else if (dp.SHR) begin
            alu_res = alu_a >> alu_amt;
        end else if (dp.SHL) begin
            alu_res = alu_a << alu_amt;
        end else if (dp.ROR) begin
`ifdef DATAPATH_ROTATE_EN
            // Doubling the word lets a plain shift wrap the vacated bits around
            alu_res = WORD_W'({alu_a, alu_a} >> alu_amt);
`else
            alu_res = '0;
`endif
        end else if (dp.ROL) begin
`ifdef DATAPATH_ROTATE_EN
            alu_res = WORD_W'(({alu_a, alu_a} << alu_amt) >> WORD_W);
`else
            alu_res = '0;
`endif
        end else if (dp.NEG) begin
            alu_res = WORD_W'(0) - alu_b;
        end else if (dp.NOT) begin
            alu_res = ~alu_b;
        end
    end

    // All ops are 32-bit; the high half of the 64-bit result is always zero
    assign alu_out = {WORD_W'(0), alu_res};

    // Register loads; a register sourcing the bus while loading takes the pre-edge value
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pc  <= '0;
            mar <= '0;
            mdr <= '0;
            ir  <= '0;
            y   <= '0;
            r2  <= '0;
            r4  <= '0;
            r5  <= '0;
            z   <= '0;
        end else begin
            if (dp.PCin)  pc  <= bus;
            if (dp.MARin) mar <= bus;
            if (dp.MDRin) mdr <= mdr_in;
            if (dp.IRin)  ir  <= bus;
            if (dp.Yin)   y   <= bus;
            if (dp.R2in)  r2  <= bus;
            if (dp.R4in)  r4  <= bus;
            if (dp.R5in)  r5  <= bus;
            if (dp.Zin)   z   <= alu_out;
        end
    end

    // Registers without a load path read as zero
    assign dp.R0  = '0;
    assign dp.R1  = '0;
    assign dp.R3  = '0;
    assign dp.R6  = '0;
    assign dp.R7  = '0;
    assign dp.R8  = '0;
    assign dp.R9  = '0;
    assign dp.R10 = '0;
    assign dp.R11 = '0;
    assign dp.R12 = '0;
    assign dp.R13 = '0;
    assign dp.R14 = '0;
    assign dp.R15 = '0;
    assign dp.Hi  = '0;
    assign dp.Lo  = '0;

    // Loadable register views
    assign dp.R2  = r2;
    assign dp.R4  = r4;
    assign dp.R5  = r5;
    assign dp.PC  = pc;
    assign dp.MAR = mar;
    assign dp.MDR = mdr;
    assign dp.IR  = ir;
    assign dp.Z   = z;

    // Combinational views
    assign dp.bus_mux_out = bus;
    assign dp.ALUout      = alu_out;

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: a driver applies directed and random control
// words and queues expected bus/ALU and post-edge register values from a
// behavioural model; monitors pop and compare away from the clock edge.
module tb_datapath;

    // Op index order equals priority order (0 = highest)
    localparam int OP_INC = 0;
    localparam int OP_ADD = 1;
    localparam int OP_SUB = 2;
    localparam int OP_AND = 3;
    localparam int OP_OR  = 4;
    localparam int OP_SHR = 5;
    localparam int OP_SHL = 6;
    localparam int OP_ROR = 7;
    localparam int OP_ROL = 8;
    localparam int OP_NEG = 9;
    localparam int OP_NOT = 10;

`ifdef DATAPATH_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    typedef struct packed {
        logic        pcout, zlowout, mdrout, r2out, r4out;
        logic        marin, zin, pcin, mdrin, irin, yin, r2in, r4in, r5in;
        logic        read;
        logic [10:0] op;
        logic [31:0] mdatain;
    } ctl_t;

    typedef struct {
        logic [31:0] bus;
        logic [63:0] alu;
    } comb_t;

    typedef struct {
        logic [31:0] pc, mar, mdr, ir, r2, r4, r5;
        logic [63:0] z;
    } regs_t;

    logic clk = 1'b0;
    logic clr;

    datapath_if dif ();

    datapath u_dut (
        .clk (clk),
        .clr (clr),
        .dp  (dif)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_pc, m_mar, m_mdr, m_ir, m_y, m_r2, m_r4, m_r5;
    logic [63:0] m_z;

    comb_t comb_q[$];
    regs_t regs_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = '0; m_mar = '0; m_mdr = '0; m_ir = '0; m_y = '0;
        m_r2 = '0; m_r4 = '0; m_r5 = '0; m_z = '0;
    endtask

    function automatic logic [31:0] rot_right(input logic [31:0] v, input int n);
        logic [31:0] r = v;
        for (int k = 0; k < n; k++) r = {r[0], r[31:1]};
        return r;
    endfunction

    function automatic logic [31:0] rot_left(input logic [31:0] v, input int n);
        logic [31:0] r = v;
        for (int k = 0; k < n; k++) r = {r[30:0], r[31]};
        return r;
    endfunction

    function automatic logic [31:0] bus_ref(input ctl_t c);
        if (c.mdrout)  return m_mdr;
        if (c.pcout)   return m_pc;
        if (c.zlowout) return m_z[31:0];
        if (c.r2out)   return m_r2;
        if (c.r4out)   return m_r4;
        return 32'd0;
    endfunction

    function automatic logic [63:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [10:0] op);
        int          sel = -1;
        int          n   = int'(b[4:0]);
        logic [31:0] r   = 32'd0;
        for (int i = 0; i < 11; i++) if (op[i] && sel < 0) sel = i;
        case (sel)
            OP_INC:  r = b + 32'd1;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SHR:  r = a >> n;
            OP_SHL:  r = a << n;
            OP_ROR:  r = ROT_EN ? rot_right(a, n) : 32'd0;
            OP_ROL:  r = ROT_EN ? rot_left(a, n) : 32'd0;
            OP_NEG:  r = 32'd0 - b;
            OP_NOT:  r = ~b;
            default: r = 32'd0;
        endcase
        return {32'd0, r};
    endfunction

    task automatic drive(input ctl_t c);
        dif.PCout = c.pcout;  dif.Zlowout = c.zlowout; dif.MDRout = c.mdrout;
        dif.R2out = c.r2out;  dif.R4out   = c.r4out;
        dif.MARin = c.marin;  dif.Zin  = c.zin;  dif.PCin = c.pcin;
        dif.MDRin = c.mdrin;  dif.IRin = c.irin; dif.Yin  = c.yin;
        dif.R2in  = c.r2in;   dif.R4in = c.r4in; dif.R5in = c.r5in;
        dif.read  = c.read;
        dif.IncPC = c.op[OP_INC]; dif.ADD = c.op[OP_ADD]; dif.SUB = c.op[OP_SUB];
        dif.AND   = c.op[OP_AND]; dif.OR  = c.op[OP_OR];  dif.SHR = c.op[OP_SHR];
        dif.SHL   = c.op[OP_SHL]; dif.ROR = c.op[OP_ROR]; dif.ROL = c.op[OP_ROL];
        dif.NEG   = c.op[OP_NEG]; dif.NOT = c.op[OP_NOT];
        dif.Mdatain = c.mdatain;
    endtask

    // One clock cycle of stimulus; expectations go to the scoreboard queues
    task automatic apply(input ctl_t c);
        logic [31:0] bv;
        logic [63:0] av;
        comb_t       ce;
        regs_t       re;
        @(posedge clk);
        #2;
        drive(c);
        bv = bus_ref(c);
        av = alu_ref(m_y, bv, c.op);
        ce.bus = bv;
        ce.alu = av;
        comb_q.push_back(ce);
        if (c.pcin)  m_pc  = bv;
        if (c.marin) m_mar = bv;
        if (c.irin)  m_ir  = bv;
        if (c.yin)   m_y   = bv;
        if (c.r2in)  m_r2  = bv;
        if (c.r4in)  m_r4  = bv;
        if (c.r5in)  m_r5  = bv;
        if (c.mdrin) m_mdr = c.read ? c.mdatain : bv;
        if (c.zin)   m_z   = av;
        re.pc = m_pc; re.mar = m_mar; re.mdr = m_mdr; re.ir = m_ir;
        re.r2 = m_r2; re.r4 = m_r4; re.r5 = m_r5; re.z = m_z;
        regs_q.push_back(re);
    endtask

    function automatic logic [31:0] zero_regs_or();
        return dif.R0 | dif.R1 | dif.R3 | dif.R6 | dif.R7 | dif.R8 | dif.R9 |
               dif.R10 | dif.R11 | dif.R12 | dif.R13 | dif.R14 | dif.R15 |
               dif.Hi | dif.Lo;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"},  dif.PC,  0);
        check({tag, "_mar"}, dif.MAR, 0);
        check({tag, "_mdr"}, dif.MDR, 0);
        check({tag, "_ir"},  dif.IR,  0);
        check({tag, "_r2"},  dif.R2,  0);
        check({tag, "_r4"},  dif.R4,  0);
        check({tag, "_r5"},  dif.R5,  0);
        check({tag, "_z"},   dif.Z,   0);
        check({tag, "_zero_regs"}, zero_regs_or(), 0);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic mid_reset();
        @(posedge clk);
        #2;
        drive('0);
        #1 clr = 1'b0;
        #1 check_all_zero("midrst");
        model_reset();
        #2 clr = 1'b1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        ctl_t c = '0;
        c.mdatain = v;
        c.read    = 1'b1;
        c.mdrin   = 1'b1;
        apply(c);
    endtask

    function automatic ctl_t rand_ctl();
        ctl_t c = '0;
        c.pcout   = ($urandom_range(3) == 0);
        c.zlowout = ($urandom_range(3) == 0);
        c.mdrout  = ($urandom_range(3) == 0);
        c.r2out   = ($urandom_range(3) == 0);
        c.r4out   = ($urandom_range(3) == 0);
        c.marin   = ($urandom_range(2) == 0);
        c.zin     = ($urandom_range(1) == 0);
        c.pcin    = ($urandom_range(3) == 0);
        c.mdrin   = ($urandom_range(2) == 0);
        c.irin    = ($urandom_range(3) == 0);
        c.yin     = ($urandom_range(2) == 0);
        c.r2in    = ($urandom_range(2) == 0);
        c.r4in    = ($urandom_range(2) == 0);
        c.r5in    = ($urandom_range(2) == 0);
        c.read    = ($urandom_range(1) == 0);
        for (int i = 0; i < 11; i++) c.op[i] = ($urandom_range(7) == 0);
        c.mdatain = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : 32'($urandom);
        return c;
    endfunction

    // Monitor: combinational bus/ALU, sampled at the falling edge
    initial begin
        comb_t ce;
        forever begin
            @(negedge clk);
            if (comb_q.size() > 0) begin
                ce = comb_q.pop_front();
                check("bus_mux_out", dif.bus_mux_out, ce.bus);
                check("ALUout", dif.ALUout, ce.alu);
            end
        end
    end

    // Monitor: register state just after each rising edge
    initial begin
        regs_t re;
        forever begin
            @(posedge clk);
            #1;
            if (regs_q.size() > 0) begin
                re = regs_q.pop_front();
                check("PC",  dif.PC,  re.pc);
                check("MAR", dif.MAR, re.mar);
                check("MDR", dif.MDR, re.mdr);
                check("IR",  dif.IR,  re.ir);
                check("R2",  dif.R2,  re.r2);
                check("R4",  dif.R4,  re.r4);
                check("R5",  dif.R5,  re.r5);
                check("Z",   dif.Z,   re.z);
                check("zero_regs", zero_regs_or(), 0);
            end
        end
    end

    // Driver
    initial begin
        ctl_t        c;
        int          op_list[6]  = '{OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND, OP_OR};
        logic [63:0] op_exp[6]   = '{64'd6, 64'd2, 64'd16, 64'd1, 64'd0, 64'd6};
        int          drain;

        clr = 1'b0;
        drive('0);
        model_reset();
        #3 check_all_zero("reset");
        #4 clr = 1'b1;

        // Memory -> MDR -> register load path
        load_mdr(32'd4);
        c = '0; c.mdrout = 1'b1; c.r2in = 1'b1; apply(c);
        load_mdr(32'd2);
        c = '0; c.mdrout = 1'b1; c.r4in = 1'b1; c.pcin = 1'b1; apply(c);
        load_mdr(32'd26);
        c = '0; c.mdrout = 1'b1; c.r5in = 1'b1; apply(c);
        apply('0);
        check("load_r2", dif.R2, 32'd4);
        check("load_r4", dif.R4, 32'd2);
        check("load_pc", dif.PC, 32'd2);
        check("load_r5", dif.R5, 32'h1A);

        // Instruction fetch
        c = '0; c.pcout = 1'b1; c.marin = 1'b1; c.op[OP_INC] = 1'b1; c.zin = 1'b1; apply(c);
        c = '0; c.zlowout = 1'b1; c.pcin = 1'b1; apply(c);
        load_mdr(32'h4A92_0000);
        c = '0; c.mdrout = 1'b1; c.irin = 1'b1; apply(c);
        apply('0);
        check("fetch_mar", dif.MAR, 32'd2);
        check("fetch_z",   dif.Z,   64'd3);
        check("fetch_pc",  dif.PC,  32'd3);
        check("fetch_ir",  dif.IR,  32'h4A92_0000);

        // Negate
        c = '0; c.r4out = 1'b1; c.op[OP_NEG] = 1'b1; c.zin = 1'b1; apply(c);
        c = '0; c.zlowout = 1'b1; c.r5in = 1'b1; apply(c);
        apply('0);
        check("neg_z",  dif.Z,  64'h0000_0000_FFFF_FFFE);
        check("neg_r5", dif.R5, 32'hFFFF_FFFE);

        // Y = R2 = 4, B = R4 = 2 through the arithmetic/logic ops
        c = '0; c.r2out = 1'b1; c.yin = 1'b1; apply(c);
        foreach (op_list[i]) begin
            c = '0; c.r4out = 1'b1; c.op[op_list[i]] = 1'b1; c.zin = 1'b1; apply(c);
            apply('0);
            check($sformatf("op%0d_z", op_list[i]), dif.Z, op_exp[i]);
        end

        // Rotates
        c = '0; c.r4out = 1'b1; c.op[OP_ROR] = 1'b1; c.zin = 1'b1; apply(c);
        apply('0);
        check("ror_z", dif.Z, ROT_EN ? 64'd1 : 64'd0);
        load_mdr(32'h8000_0000);
        c = '0; c.mdrout = 1'b1; c.yin = 1'b1; apply(c);
        load_mdr(32'd1);
        c = '0; c.mdrout = 1'b1; c.r4in = 1'b1; apply(c);
        c = '0; c.r4out = 1'b1; c.op[OP_ROL] = 1'b1; c.zin = 1'b1; apply(c);
        apply('0);
        check("rol_z", dif.Z, ROT_EN ? 64'd1 : 64'd0);

        // Simultaneous bus selects resolve by priority (PC=3, R2=4, R4=1, MDR=1)
        c = '0; c.pcout = 1'b1; c.r2out = 1'b1; c.r4out = 1'b1; apply(c);
        #1 check("multi_sel_pc", dif.bus_mux_out, 32'd3);
        c = '0; c.r2out = 1'b1; c.r4out = 1'b1; apply(c);
        #1 check("multi_sel_r2", dif.bus_mux_out, 32'd4);

        // Reset mid-sequence discards all state, then loads resume
        mid_reset();
        load_mdr(32'd7);
        c = '0; c.mdrout = 1'b1; c.pcin = 1'b1; apply(c);
        apply('0);
        check("post_reset_pc", dif.PC, 32'd7);

        // Randomized traffic with an asynchronous reset in the middle
        for (int n = 0; n < 300; n++) apply(rand_ctl());
        mid_reset();
        for (int n = 0; n < 300; n++) apply(rand_ctl());
        apply('0);

        // Drain the scoreboard with a bounded wait
        drain = 0;
        while ((comb_q.size() > 0 || regs_q.size() > 0) && drain < 20) begin
            @(negedge clk);
            drain++;
        end
        @(posedge clk);
        #3;
        if (comb_q.size() > 0 || regs_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d/%0d expectations left, expected 0/0", comb_q.size(), regs_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
